// File: rtl/image_capture_pkg.sv
// Shared definitions for the camera capture path.
//   cap_state_e    : capture FSM state encoding
//   BYTES_PER_WORD : bytes per packed word at the default 32-bit width
//   bytes_per_word : lane count for an arbitrary (multiple-of-8) word width
package image_capture_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_VSYNC  = 3'd1,
    VSYNC_HIGH  = 3'd2,
    WAIT_LINE   = 3'd3,
    LINE        = 3'd4
  } cap_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// Assembles camera bytes into little-endian words.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : discard any partial word (highest priority)
//   capture_i      : byte_i goes into the current lane
//   flush_i        : emit a partial word with zero-padded upper lanes
//   byte_i         : camera byte
//   word_o         : word being emitted (valid only with word_valid_o)
//   word_valid_o   : a word is complete this cycle (combinational)
module byte_lane_packer
  import image_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BYTES_PER_WORD * 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  capture_i,
  input  logic                  flush_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_valid_o
);

  localparam int unsigned BPW   = bytes_per_word(DATA_WIDTH);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BPW - 1);

  logic [DATA_WIDTH-1:0] lanes_q, lanes_d, lanes_ins;
  logic [IDX_W-1:0]      idx_q, idx_d;

  // Lanes above byte_index are kept at zero (the register is cleared after
  // every emitted word), so a flush needs no explicit padding mask.
  always_comb begin
    lanes_ins = lanes_q;
    for (int unsigned l = 0; l < BPW; l++) begin
      if (idx_q == IDX_W'(l)) lanes_ins[l*8 +: 8] = byte_i;
    end
  end

  always_comb begin
    lanes_d      = lanes_q;
    idx_d        = idx_q;
    word_o       = lanes_q;
    word_valid_o = 1'b0;
    if (clear_i) begin
      lanes_d = '0;
      idx_d   = '0;
    end else if (capture_i) begin
      word_o = lanes_ins;
      if (idx_q == LAST) begin
        word_valid_o = 1'b1;
        lanes_d      = '0;
        idx_d        = '0;
      end else begin
        lanes_d = lanes_ins;
        idx_d   = idx_q + IDX_W'(1);
      end
    end else if (flush_i) begin
      word_valid_o = (idx_q != '0);
      lanes_d      = '0;
      idx_d        = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Camera byte stream to FIFO word packer with frame/line sequencing.
//   clock, reset_n  : pixel clock, asynchronous active-low reset
//   enable          : capture enable; low returns to IDLE and drops partial data
//   vsync, href     : camera frame sync / line valid
//   pixel_data      : camera byte
//   fifo_ready/full : downstream FIFO status; a push is dropped unless ready and not full
//   fifo_data       : last pushed word (held between pushes)
//   fifo_push       : one-cycle push strobe
//   fifo_clear      : one-cycle strobe at frame start (or frame abort)
//   frame_done      : one-cycle pulse after line FRAME_LINES completes
//   overflow        : sticky; a word was dropped in the current frame
//   line_count      : lines completed in the current frame (saturating)
module pixel_packer
  import image_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = BYTES_PER_WORD * 8,
  parameter int unsigned FRAME_LINES = 480
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            pixel_data,
  input  logic                  fifo_ready,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_push,
  output logic                  fifo_clear,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [15:0]           line_count
);

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("pixel_packer: DATA_WIDTH must be a non-zero multiple of 8");
  end

  localparam logic [15:0] LAST_LINE = 16'(FRAME_LINES);

  cap_state_e            state_q, state_d;
  logic                  vsync_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  push_q, push_d;
  logic                  clear_q, clear_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           lc_q, lc_d, lc_inc;

  logic                  vsync_rise;
  logic                  frame_start;
  logic                  pk_clear, pk_capture, pk_flush, pk_valid;
  logic [DATA_WIDTH-1:0] pk_word;

  assign vsync_rise = vsync & ~vsync_q;

  byte_lane_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .clear_i     (pk_clear),
    .capture_i   (pk_capture),
    .flush_i     (pk_flush),
    .byte_i      (pixel_data),
    .word_o      (pk_word),
    .word_valid_o(pk_valid)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    push_d      = 1'b0;
    clear_d     = 1'b0;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    lc_d        = lc_q;
    frame_start = 1'b0;
    pk_clear    = 1'b0;
    pk_capture  = 1'b0;
    pk_flush    = 1'b0;
    lc_inc      = (lc_q == 16'hFFFF) ? lc_q : lc_q + 16'd1;

    if (!enable) begin
      state_d  = IDLE;
      pk_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:       state_d = WAIT_VSYNC;
        WAIT_VSYNC: frame_start = vsync_rise;
        VSYNC_HIGH: if (!vsync) state_d = WAIT_LINE;
        WAIT_LINE: begin
          if (vsync_rise) begin
            frame_start = 1'b1;
          end else if (href) begin
            pk_capture = 1'b1;
            state_d    = LINE;
          end
        end
        LINE: begin
          if (vsync_rise) begin
            frame_start = 1'b1;
          end else if (href) begin
            pk_capture = 1'b1;
          end else begin
            pk_flush = 1'b1;
            lc_d     = lc_inc;
            state_d  = WAIT_LINE;
            if (lc_inc == LAST_LINE) begin
              done_d  = 1'b1;
              state_d = WAIT_VSYNC;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A frame start (including an abort mid-line) drops the partial word;
      // the packer clear overrides capture/flush so no push can coincide.
      if (frame_start) begin
        state_d  = VSYNC_HIGH;
        clear_d  = 1'b1;
        lc_d     = '0;
        ovf_d    = 1'b0;
        pk_clear = 1'b1;
      end

      if (pk_valid) begin
        if (fifo_full || !fifo_ready) begin
          ovf_d = 1'b1;
        end else begin
          push_d = 1'b1;
          data_d = pk_word;
        end
      end
    end
  end

  // vsync_q resets high so a vsync already asserted at release is not an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vsync_q <= 1'b1;
      data_q  <= '0;
      push_q  <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      data_q  <= data_d;
      push_q  <= push_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      lc_q    <= lc_d;
    end
  end

  assign fifo_data  = data_q;
  assign fifo_push  = push_q;
  assign fifo_clear = clear_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign line_count = lc_q;

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  pixel_data = '0;
  logic        fifo_ready = 1'b1;
  logic        fifo_full = 1'b0;
  logic [31:0] fifo_data;
  logic        fifo_push;
  logic        fifo_clear;
  logic        frame_done;
  logic        overflow;
  logic [15:0] line_count;

  pixel_packer #(
    .DATA_WIDTH (32),
    .FRAME_LINES(2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .vsync     (vsync),
    .href      (href),
    .pixel_data(pixel_data),
    .fifo_ready(fifo_ready),
    .fifo_full (fifo_full),
    .fifo_data (fifo_data),
    .fifo_push (fifo_push),
    .fifo_clear(fifo_clear),
    .frame_done(frame_done),
    .overflow  (overflow),
    .line_count(line_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          clr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_data = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard side: every push must match the oldest expected word and cycle.
  always @(negedge clock) begin
    exp_t e;
    if (fifo_push) begin
      last_data = fifo_data;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_push: got data %h at cycle %0d, required no push", fifo_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (fifo_data !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL push_word: got %h @%0d, required %h @%0d", fifo_data, cyc, e.data, e.cyc);
        end
      end
    end
    if (fifo_push || fifo_clear) begin
      n_cmp++;
      if (fifo_push && fifo_clear) begin
        n_err++;
        $display("FAIL push_clear_excl: got push=1 clear=1, required not both");
      end
    end
    if (fifo_clear) clr_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives nb consecutive bytes starting at 'first' and, if end_line, drops
  // href. Expected words come from a little-endian accumulator with zero pad.
  // bad_kind 1 = fifo_full, 2 = fifo_ready low, applied on step bad_step
  // (steps 0..nb-1 are bytes, step nb is the href-low cycle).
  task automatic send_line(input logic [7:0] first, input int nb, input bit expect_push,
                           input bit end_line, input int bad_step, input int bad_kind);
    logic [31:0] w;
    logic [7:0]  b;
    int          n;
    exp_t        e;
    w = '0;
    n = 0;
    for (int i = 0; i < nb; i++) begin
      @(posedge clock); #1;
      fifo_full  = (bad_step == i && bad_kind == 1);
      fifo_ready = !(bad_step == i && bad_kind == 2);
      b = first + 8'(i);
      href = 1'b1;
      pixel_data = b;
      w[n*8 +: 8] = b;
      n++;
      if (n == 4) begin
        if (expect_push && bad_step != i) begin
          e.data = w;
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
        w = '0;
        n = 0;
      end
    end
    if (end_line) begin
      @(posedge clock); #1;
      fifo_full  = (bad_step == nb && bad_kind == 1);
      fifo_ready = !(bad_step == nb && bad_kind == 2);
      href = 1'b0;
      pixel_data = '0;
      if (n != 0 && expect_push && bad_step != nb) begin
        e.data = w;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      @(posedge clock); #1;
      fifo_full  = 1'b0;
      fifo_ready = 1'b1;
    end
  endtask

  task automatic vsync_pulse(output int nclr);
    int c0;
    c0 = clr_cnt;
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(3);
    nclr = clr_cnt - c0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    vsync   = 1'b1;
    tick(3);
    n_cmp++; if (fifo_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h, required 0", fifo_data); end
    n_cmp++; if (fifo_push !== 1'b0) begin n_err++; $display("FAIL rst_push: got %b, required 0", fifo_push); end
    n_cmp++; if (fifo_clear !== 1'b0) begin n_err++; $display("FAIL rst_clear: got %b, required 0", fifo_clear); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, required 0", frame_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
    n_cmp++; if (line_count !== 16'h0) begin n_err++; $display("FAIL rst_lines: got %0d, required 0", line_count); end
    reset_n = 1'b1;
    tick(4);
    n_cmp++; if (clr_cnt != 0) begin n_err++; $display("FAIL held_vsync_no_start: got %0d clears, required 0", clr_cnt); end
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic test_two_words();
    int nclr;
    vsync_pulse(nclr);
    n_cmp++; if (nclr != 1) begin n_err++; $display("FAIL tw_clear: got %0d pulses, required 1", nclr); end
    send_line(8'h01, 8, 1'b1, 1'b1, -1, 0);
    tick(3);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL tw_pending: got %0d missing pushes, required 0", exp_q.size()); end
    n_cmp++; if (last_data !== 32'h08070605) begin n_err++; $display("FAIL tw_last: got %h, required 08070605", last_data); end
    n_cmp++; if (line_count !== 16'd1) begin n_err++; $display("FAIL tw_lines: got %0d, required 1", line_count); end
  endtask

  task automatic test_partial_flush();
    int nclr;
    vsync_pulse(nclr);
    n_cmp++; if (line_count !== 16'd0) begin n_err++; $display("FAIL pf_lines0: got %0d, required 0", line_count); end
    send_line(8'hAA, 6, 1'b1, 1'b1, -1, 0);
    tick(4);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pf_pending: got %0d missing pushes, required 0", exp_q.size()); end
    n_cmp++; if (fifo_data !== 32'h0000AFAE) begin n_err++; $display("FAIL pf_hold: got %h, required 0000afae", fifo_data); end
  endtask

  task automatic test_frame_done();
    int nclr, d0;
    vsync_pulse(nclr);
    d0 = done_cnt;
    send_line(8'h11, 4, 1'b1, 1'b1, -1, 0);
    n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL fd_early: got %0d pulses, required 0", done_cnt - d0); end
    send_line(8'h21, 4, 1'b1, 1'b1, -1, 0);
    tick(2);
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL fd_pulse: got %0d pulses, required 1", done_cnt - d0); end
    n_cmp++; if (line_count !== 16'd2) begin n_err++; $display("FAIL fd_lines: got %0d, required 2", line_count); end
    send_line(8'h31, 4, 1'b0, 1'b1, -1, 0);
    tick(3);
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL fd_extra: got %0d pulses, required 1", done_cnt - d0); end
    n_cmp++; if (line_count !== 16'd2) begin n_err++; $display("FAIL fd_ignored: got %0d, required 2", line_count); end
  endtask

  task automatic test_overflow();
    int nclr;
    vsync_pulse(nclr);
    send_line(8'h01, 4, 1'b1, 1'b1, 3, 1);
    tick(4);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ov_full: got %b, required 1", overflow); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ov_pending: got %0d, required 0", exp_q.size()); end
    vsync_pulse(nclr);
    n_cmp++; if (nclr != 1) begin n_err++; $display("FAIL ov_clear: got %0d pulses, required 1", nclr); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ov_cleared: got %b, required 0", overflow); end
    send_line(8'hC1, 2, 1'b1, 1'b1, 2, 2);
    tick(2);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ov_notready: got %b, required 1", overflow); end
    n_cmp++; if (line_count !== 16'd1) begin n_err++; $display("FAIL ov_lines: got %0d, required 1", line_count); end
  endtask

  task automatic test_abort();
    int c0;
    send_line(8'h41, 3, 1'b1, 1'b0, -1, 0);
    c0 = clr_cnt;
    href  = 1'b0;
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(3);
    n_cmp++; if (clr_cnt - c0 != 1) begin n_err++; $display("FAIL ab_clear: got %0d pulses, required 1", clr_cnt - c0); end
    n_cmp++; if (line_count !== 16'd0) begin n_err++; $display("FAIL ab_lines: got %0d, required 0", line_count); end
    send_line(8'h51, 4, 1'b1, 1'b1, -1, 0);
    tick(2);
    n_cmp++; if (fifo_data !== 32'h54535251) begin n_err++; $display("FAIL ab_fresh: got %h, required 54535251", fifo_data); end
  endtask

  task automatic test_reset_midline();
    int nclr;
    vsync_pulse(nclr);
    send_line(8'h61, 2, 1'b1, 1'b0, -1, 0);
    reset_n = 1'b0;
    href    = 1'b0;
    tick(2);
    n_cmp++; if (fifo_data !== 32'h0) begin n_err++; $display("FAIL rm_data: got %h, required 0", fifo_data); end
    n_cmp++; if (line_count !== 16'h0 || overflow !== 1'b0) begin n_err++; $display("FAIL rm_state: got lines %0d ovf %b, required 0 0", line_count, overflow); end
    reset_n = 1'b1;
    tick(2);
    send_line(8'h71, 4, 1'b0, 1'b1, -1, 0);
    vsync_pulse(nclr);
    send_line(8'h81, 4, 1'b1, 1'b1, -1, 0);
    tick(2);
    n_cmp++; if (fifo_data !== 32'h84838281) begin n_err++; $display("FAIL rm_fresh: got %h, required 84838281", fifo_data); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rm_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_disable();
    int nclr;
    vsync_pulse(nclr);
    send_line(8'h91, 2, 1'b1, 1'b0, -1, 0);
    enable = 1'b0;
    href   = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(2);
    vsync_pulse(nclr);
    n_cmp++; if (nclr != 1) begin n_err++; $display("FAIL dis_clear: got %0d pulses, required 1", nclr); end
    send_line(8'hA1, 4, 1'b1, 1'b1, -1, 0);
    tick(2);
    n_cmp++; if (fifo_data !== 32'hA4A3A2A1) begin n_err++; $display("FAIL dis_fresh: got %h, required a4a3a2a1", fifo_data); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL dis_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_partial_flush();
    test_frame_done();
    test_overflow();
    test_abort();
    test_reset_midline();
    test_disable();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
